apb_req_arbiter: RTL and testbench

Shares the single APB slave-to-memory interface (10-bit address, 32-bit data) between `NUM_REQ` internal requesters. Arbitrates round-robin, captures one command at a time, and sequences the APB SETUP and ACCESS phases as the APB master. Waits on `pready`, returns read data and completion to the winning requester, and aborts transfers that exceed a timeout.

---
 rtl/apb_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/apb_req_arbiter.sv | 88 ++++++++
 tb/tb_apb_req_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and default sizing for the APB request arbiter.
package apb_arb_pkg;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_arb_state_e;
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; priority moves past the winner on advance.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr, ptr_nx, idx;
  // Scan from lowest priority to highest so the highest-priority hit is written last.
  always_comb begin
    grant  = '0;
    ptr_nx = ptr;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        grant  = NUM_REQ'(1) << idx;
        ptr_nx = PW'((int'(ptr) + i + 1) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (advance) ptr <= ptr_nx;
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master port between NUM_REQ requesters with timeout abort.
module apb_req_arbiter import apb_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic                      rsp_err_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i
);
  localparam int CW = $clog2(TIMEOUT);
  apb_arb_state_e state, state_nx;
  apb_cmd_t cmd;
  logic [NUM_REQ-1:0] grant, win;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] rdata, sel_wdata;
  logic [ADDR_W-1:0] sel_addr;
  logic sel_write, err, take, act, expired;
  assign take    = state == IDLE && |req_valid_i;
  assign act     = state == SETUP || state == ACCESS;
  assign expired = cnt == CW'(TIMEOUT - 1);
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk(clk), .reset(reset), .req(req_valid_i), .advance(take), .grant(grant)
  );
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        sel_write = req_write_i[i];
        sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
      end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? SETUP : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = (pready_i || expired) ? RESP : ACCESS;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cmd   <= '0;
      win   <= '0;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        cmd <= '{write: sel_write, addr: DEF_ADDR_W'(sel_addr), wdata: DEF_DATA_W'(sel_wdata)};
        win <= grant;
      end
      cnt   <= state == ACCESS ? cnt + 1'b1 : '0;
      rdata <= (state == ACCESS && pready_i && !cmd.write) ? prdata_i : '0;
      err   <= state == ACCESS && !pready_i && expired;
    end
  // Grant is gated by reset so every output reads 0 while reset is held.
  assign req_ready_o = (state == IDLE && reset) ? grant : '0;
  assign rsp_valid_o = state == RESP ? win : '0;
  assign rsp_err_o   = err;
  assign rsp_rdata_o = rdata;
  assign psel_o      = act;
  assign penable_o   = state == ACCESS;
  assign pwrite_o    = act && cmd.write;
  assign paddr_o     = act ? ADDR_W'(cmd.addr) : '0;
  assign pwdata_o    = act ? DATA_W'(cmd.wdata) : '0;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: randomized scenarios checked against a transaction-level model and APB slave memory.
module tb_apb_req_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic rsp_err, psel, penable, pwrite, pready;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic [9:0] paddr;
  logic [31:0] mem [1024];
  logic [31:0] slave_mem [1024];
  int rr_ptr;
  int n_checks = 0;
  int n_pass = 0;

  apb_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(10), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready)
  );

  always #5 clk = ~clk;

  function automatic logic [81:0] obs();
    return {req_ready, rsp_valid, rsp_err, rsp_rdata, psel, penable, pwrite, paddr, pwdata};
  endfunction

  // One whole transfer from an IDLE grant cycle; the slave answers after `waits` wait states
  // (waits >= TIMEOUT means it never answers).
  task automatic xfer(input logic [1:0] v, input int waits, input bit hold, input string tag);
    int win;
    logic [1:0] oh;
    logic w;
    logic [9:0] a;
    logic [31:0] d, rd;
    logic [81:0] e;
    bit to;
    win = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (v[(rr_ptr + i) % NUM_REQ]) win = (rr_ptr + i) % NUM_REQ;
    oh = 2'(1 << win);
    w  = req_write[win];
    a  = req_addr[win*10 +: 10];
    d  = req_wdata[win*32 +: 32];
    to = waits >= TIMEOUT;
    rd = (w || to) ? 32'h0 : mem[a];
    req_valid = v;
    @(negedge clk);
    e = {oh, 2'b00, 1'b0, 32'h0, 3'b000, 10'h0, 32'h0};
    n_checks++;
    if (obs() !== e) $display("FAIL %s.grant got %h exp %h", tag, obs(), e); else n_pass++;
    @(posedge clk); #1;
    if (!hold) req_valid = 2'b00;
    @(negedge clk);
    e = {2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, w, a, d};
    n_checks++;
    if (obs() !== e) $display("FAIL %s.setup got %h exp %h", tag, obs(), e); else n_pass++;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(posedge clk); #1;
      pready = k == waits;
      prdata = pready ? slave_mem[paddr] : $urandom;
      @(negedge clk);
      e = {2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, w, a, d};
      n_checks++;
      if (obs() !== e) $display("FAIL %s.access%0d got %h exp %h", tag, k, obs(), e); else n_pass++;
      if (pready && pwrite) slave_mem[paddr] = pwdata;
      if (k == waits) break;
    end
    @(posedge clk); #1;
    pready = 1'b0;
    prdata = $urandom;
    @(negedge clk);
    e = {2'b00, oh, to, rd, 3'b000, 10'h0, 32'h0};
    n_checks++;
    if (obs() !== e) $display("FAIL %s.resp got %h exp %h", tag, obs(), e); else n_pass++;
    @(posedge clk); #1;
    rr_ptr = (win + 1) % NUM_REQ;
    if (w && !to) mem[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 2'b00;
    pready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (obs() !== 82'h0) $display("FAIL reset got %h exp 0", obs()); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    rr_ptr = 0;
  endtask

  task automatic test_single_write();
    req_write = 2'b01;
    req_addr[9:0] = 10'h00F;
    req_wdata[31:0] = 32'hdeadbee0;
    xfer(2'b01, 0, 1'b0, "single_write");
    n_checks++;
    if (slave_mem[15] !== 32'hdeadbee0) $display("FAIL single_write.mem got %h exp deadbee0", slave_mem[15]);
    else n_pass++;
  endtask

  task automatic test_read_back();
    req_write = 2'b00;
    req_addr[9:0] = 10'h00F;
    req_wdata[31:0] = $urandom;
    xfer(2'b01, 2, 1'b0, "read_back");
  endtask

  task automatic test_fairness();
    test_reset();
    req_write = 2'b11;
    req_addr = {10'h011, 10'h010};
    for (int i = 0; i < 4; i++) begin
      req_wdata = {32'hdeadbee0 + 32'(i), 32'hdeadbee0 + 32'(i)};
      xfer(2'b11, i % 2, 1'b1, "fairness");
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    req_write = 2'b00;
    req_addr = {10'h2A5, 10'h00F};
    xfer(2'b10, TIMEOUT, 1'b0, "timeout");
    req_write = 2'b01;
    req_wdata[31:0] = 32'h12345678;
    xfer(2'b01, 1, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_mid();
    req_write = 2'b00;
    req_addr = {10'h100, 10'h011};
    req_valid = 2'b01;
    repeat (3) begin
      @(posedge clk); #1;
      req_valid = 2'b00;
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 82'h0) $display("FAIL reset_mid.async got %h exp 0", obs()); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs() !== 82'h0) $display("FAIL reset_mid.hold got %h exp 0", obs()); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs() !== 82'h0) $display("FAIL reset_mid.idle got %h exp 0", obs()); else n_pass++;
    @(posedge clk); #1;
    rr_ptr = 0;
    req_write = 2'b11;
    req_wdata = {32'hbbbb0001, 32'haaaa0000};
    xfer(2'b11, 0, 1'b0, "reset_mid.prio");
  endtask

  task automatic test_back_to_back();
    req_write = 2'b10;
    for (int i = 0; i < 4; i++) begin
      req_addr[19:10] = 10'(i + 32);
      req_wdata[63:32] = $urandom;
      xfer(2'b10, int'($urandom_range(0, 3)), 1'b1, "back_to_back");
    end
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      req_write = 2'($urandom);
      req_addr  = {10'($urandom), 10'($urandom)};
      req_wdata = {32'($urandom), 32'($urandom)};
      xfer(2'($urandom_range(1, 3)), ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 3)),
           1'($urandom), "random");
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      slave_mem[i] = mem[i];
    end
    req_write = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    prdata = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
